vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_wrap_counter.sv | 29 ++
 rtl/vga_timing_gen.sv | 110 +++++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults and coordinate type for the 640x480@60 VGA display path.
package vga_pkg;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_FRONT   = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_BACK    = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_FRONT   = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_BACK    = 33;
   localparam int unsigned DEF_CLK_DIV   = 2;

   localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   localparam int unsigned COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   // Half-open window test lo <= v < hi, used for the sync pulse decodes.
   function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-N counter with enable; wrap_c flags the enabled step from N-1 back to 0.
module vga_wrap_counter #(
   parameter int unsigned N = 2,
   parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap_c
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   if (N < 1) begin : g_bad_modulus
      $error("vga_wrap_counter: N must be at least 1");
   end

   assign wrap_c = en && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en) begin
         count <= wrap_c ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable divider, h/v counters, sync/blank decode.
// Define VGA_OUTPUT_REG_EN to register hs/vs/blank/DrawX/DrawY one pixel behind the counters.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT   = DEF_H_FRONT,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BACK    = DEF_H_BACK,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT   = DEF_V_FRONT,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BACK    = DEF_V_BACK,
   parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
   input  logic   Clk,
   input  logic   Reset_n,
   output logic   pixel_en,
   output logic   hs,
   output logic   vs,
   output logic   blank,
   output coord_t DrawX,
   output coord_t DrawY,
   output logic   frame_tick
);

   localparam int unsigned LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
   localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
   localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if ((LINE_LEN > (1 << COORD_W)) || (FRAME_LINES > (1 << COORD_W))) begin : g_bad_geometry
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   logic [DIV_W-1:0] div_unused;
   coord_t           hc;
   coord_t           vc;
   logic             hc_wrap_c;
   logic             hs_c;
   logic             vs_c;
   logic             blank_c;

   // Pixel enable: divider wraps every CLK_DIV clocks (always high when CLK_DIV is 1).
   vga_wrap_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .en     (1'b1),
      .count  (div_unused),
      .wrap_c (pixel_en)
   );

   vga_wrap_counter #(.N(LINE_LEN), .W(COORD_W)) u_hcount (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .en     (pixel_en),
      .count  (hc),
      .wrap_c (hc_wrap_c)
   );

   // Vertical wrap only happens on the last pixel of the last line, i.e. the frame tick.
   vga_wrap_counter #(.N(FRAME_LINES), .W(COORD_W)) u_vcount (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .en     (hc_wrap_c),
      .count  (vc),
      .wrap_c (frame_tick)
   );

   assign hs_c    = !in_window(hc, HS_START, HS_END);
   assign vs_c    = !in_window(vc, VS_START, VS_END);
   assign blank_c = (hc < H_VIS_END) && (vc < V_VIS_END);

`ifdef VGA_OUTPUT_REG_EN
   // Pin-facing copies, one pixel behind the counters.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hs    <= 1'b1;
         vs    <= 1'b1;
         blank <= 1'b0;
         DrawX <= '0;
         DrawY <= '0;
      end else if (pixel_en) begin
         hs    <= hs_c;
         vs    <= vs_c;
         blank <= blank_c;
         DrawX <= hc;
         DrawY <= vc;
      end
   end
`else
   always_comb begin
      hs    = hs_c;
      vs    = vs_c;
      blank = blank_c;
      DrawX = hc;
      DrawY = vc;
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: scoreboarded small-geometry instance plus directed checks on the default geometry.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int unsigned S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 4;
   localparam int unsigned S_VV = 12, S_VF = 3, S_VS = 2, S_VB = 5;
   localparam int unsigned S_DIV   = 2;
   localparam int unsigned S_HT    = S_HV + S_HF + S_HS + S_HB;
   localparam int unsigned S_VT    = S_VV + S_VF + S_VS + S_VB;
   localparam int unsigned S_FRAME = S_HT * S_VT * S_DIV;

`ifdef VGA_OUTPUT_REG_EN
   localparam logic RST_BLANK = 1'b0;
   localparam int unsigned FT_X = S_HT - 2, FT_NX = S_HT - 1, FT_NY = S_VT - 1;
`else
   localparam logic RST_BLANK = 1'b1;
   localparam int unsigned FT_X = S_HT - 1, FT_NX = 0, FT_NY = 0;
`endif

   typedef struct packed {
      logic   pe;
      logic   hs;
      logic   vs;
      logic   blank;
      logic   ft;
      coord_t x;
      coord_t y;
   } obs_t;

   logic clk = 1'b0;
   logic rst_s_n = 1'b0;
   logic rst_f_n = 1'b0;
   always #5 clk = ~clk;

   logic   s_pe, s_hs, s_vs, s_blank, s_ft;
   coord_t s_x, s_y;
   logic   f_pe, f_hs, f_vs, f_blank, f_ft;
   coord_t f_x, f_y;

   vga_timing_gen #(
      .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
      .CLK_DIV(S_DIV)
   ) dut_s (
      .Clk(clk), .Reset_n(rst_s_n), .pixel_en(s_pe), .hs(s_hs), .vs(s_vs),
      .blank(s_blank), .DrawX(s_x), .DrawY(s_y), .frame_tick(s_ft)
   );

   vga_timing_gen dut_f (
      .Clk(clk), .Reset_n(rst_f_n), .pixel_en(f_pe), .hs(f_hs), .vs(f_vs),
      .blank(f_blank), .DrawX(f_x), .DrawY(f_y), .frame_tick(f_ft)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model of the small instance
   int unsigned m_div, m_hc, m_vc;
   logic        r_hs, r_vs, r_blank;
   coord_t      r_x, r_y;
   obs_t        sb_q[$];
   bit          sb_on = 1'b0;

   function automatic logic m_hs_dec(input int unsigned hc);
      return !((hc >= S_HV + S_HF) && (hc < S_HV + S_HF + S_HS));
   endfunction

   function automatic logic m_vs_dec(input int unsigned vc);
      return !((vc >= S_VV + S_VF) && (vc < S_VV + S_VF + S_VS));
   endfunction

   function automatic logic m_blank_dec(input int unsigned hc, input int unsigned vc);
      return (hc < S_HV) && (vc < S_VV);
   endfunction

   task automatic model_reset();
      m_div = 0; m_hc = 0; m_vc = 0;
      r_hs = 1'b1; r_vs = 1'b1; r_blank = 1'b0; r_x = '0; r_y = '0;
   endtask

   task automatic model_step();
      logic pe;
      pe = (m_div == S_DIV - 1);
      if (pe) begin
         r_hs    = m_hs_dec(m_hc);
         r_vs    = m_vs_dec(m_vc);
         r_blank = m_blank_dec(m_hc, m_vc);
         r_x     = coord_t'(m_hc);
         r_y     = coord_t'(m_vc);
         if (m_hc == S_HT - 1) begin
            m_hc = 0;
            m_vc = (m_vc == S_VT - 1) ? 0 : m_vc + 1;
         end else begin
            m_hc = m_hc + 1;
         end
      end
      m_div = pe ? 0 : m_div + 1;
   endtask

   function automatic obs_t model_out();
      obs_t o;
      o.pe = (m_div == S_DIV - 1);
      o.ft = o.pe && (m_hc == S_HT - 1) && (m_vc == S_VT - 1);
`ifdef VGA_OUTPUT_REG_EN
      o.hs = r_hs; o.vs = r_vs; o.blank = r_blank; o.x = r_x; o.y = r_y;
`else
      o.hs    = m_hs_dec(m_hc);
      o.vs    = m_vs_dec(m_vc);
      o.blank = m_blank_dec(m_hc, m_vc);
      o.x     = coord_t'(m_hc);
      o.y     = coord_t'(m_vc);
`endif
      return o;
   endfunction

   always @(posedge clk) begin
      if (sb_on) begin
         if (rst_s_n) model_step();
         sb_q.push_back(model_out());
      end
   end

   always @(negedge clk) begin
      obs_t got, exp;
      if (sb_on && (sb_q.size() > 0)) begin
         exp = sb_q.pop_front();
         got = {s_pe, s_hs, s_vs, s_blank, s_ft, s_x, s_y};
         check("sb_small", 32'(got), 32'(exp));
      end
   end

   int          n, gap, hs_low_pe, ft_n, last_ft;
   bit          found, in_low, have_last, ft_prev, prev_hs, prev_blank;
   coord_t      hs_fall_x, hs_rise_x, blank_fall_x, wrap_y, prev_x;

   initial begin
      #3;
      check("rst_f_pe", 32'(f_pe), 32'(0));
      check("rst_f_hs", 32'(f_hs), 32'(1));
      check("rst_f_vs", 32'(f_vs), 32'(1));
      check("rst_f_blank", 32'(f_blank), 32'(RST_BLANK));
      check("rst_f_xy", {12'd0, f_x, f_y}, 32'(0));
      check("rst_f_ft", 32'(f_ft), 32'(0));
      check("rst_s_all", 32'({s_pe, s_hs, s_vs, s_blank, s_ft, s_x, s_y}),
            32'({1'b0, 1'b1, 1'b1, RST_BLANK, 1'b0, 10'd0, 10'd0}));

      @(negedge clk); #2;
      model_reset();
      sb_on   = 1'b1;
      rst_s_n = 1'b1;
      rst_f_n = 1'b1;

      // First pixel enable: cycle 1 is the release cycle
      n = 1; found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk); #1;
         n++;
         if (f_pe) found = 1'b1;
      end
      check("first_pe_cycle", 32'(n), 32'(2));
      gap = 0; found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk); #1;
         gap++;
         if (f_pe) found = 1'b1;
      end
      check("pe_period", 32'(gap), 32'(2));

      // One full default-geometry line
      hs_fall_x = '1; hs_rise_x = '1; blank_fall_x = '1; wrap_y = '1;
      hs_low_pe = 0; in_low = 1'b0;
      prev_hs = f_hs; prev_blank = f_blank; prev_x = f_x;
      for (int i = 0; i < 1700; i++) begin
         @(posedge clk); #1;
         if (prev_hs && !f_hs && hs_fall_x == 10'h3ff) begin
            hs_fall_x = f_x; in_low = 1'b1;
         end
         if (!prev_hs && f_hs && in_low) begin
            hs_rise_x = f_x; in_low = 1'b0;
         end
         if (in_low && f_pe) hs_low_pe++;
         if (prev_blank && !f_blank && blank_fall_x == 10'h3ff) blank_fall_x = f_x;
         if (prev_x == 10'd799 && f_x == 10'd0 && wrap_y == 10'h3ff) wrap_y = f_y;
         prev_hs = f_hs; prev_blank = f_blank; prev_x = f_x;
      end
      check("hs_fall_x", 32'(hs_fall_x), 32'(656));
      check("hs_rise_x", 32'(hs_rise_x), 32'(752));
      check("hs_low_pixels", 32'(hs_low_pe), 32'(96));
      check("blank_fall_x", 32'(blank_fall_x), 32'(640));
      check("line_wrap_y", 32'(wrap_y), 32'(1));

      // Frame tick on the small instance over exactly three frames
      ft_n = 0; last_ft = 0; have_last = 1'b0; ft_prev = 1'b0;
      for (int i = 0; i < 3 * S_FRAME; i++) begin
         @(posedge clk); #1;
         if (ft_prev) begin
            check("ft_next_x", 32'(s_x), 32'(FT_NX));
            check("ft_next_y", 32'(s_y), 32'(FT_NY));
         end
         ft_prev = s_ft;
         if (s_ft) begin
            ft_n++;
            check("ft_x", 32'(s_x), 32'(FT_X));
            check("ft_y", 32'(s_y), 32'(S_VT - 1));
            if (have_last) check("ft_period", 32'(i - last_ft), 32'(S_FRAME));
            last_ft = i; have_last = 1'b1;
         end
      end
      check("ft_count", 32'(ft_n), 32'(3));

      // Mid-frame asynchronous reset while hs is low
      found = 1'b0;
      for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
         @(negedge clk); #1;
         if (s_x == 10'd23 && s_y == 10'd8) found = 1'b1;
      end
      check("midrst_found", 32'(found), 32'(1));
      check("midrst_hs_pre", 32'(s_hs), 32'(0));
      rst_s_n = 1'b0;
      model_reset();
      #1;
      check("midrst_hs", 32'(s_hs), 32'(1));
      check("midrst_x", 32'(s_x), 32'(0));
      check("midrst_y", 32'(s_y), 32'(0));
      repeat (3) @(negedge clk);
      #2 rst_s_n = 1'b1;

      repeat (S_FRAME + 50) @(negedge clk);
      sb_on = 1'b0;
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
